// File: rtl/xbar_pkg.sv
// Shared constants and types for the crossbar egress (receive) side.
package xbar_pkg;

    localparam int unsigned PORTS_C     = 4;
    localparam int unsigned DATA_W_C    = 8;
    localparam int unsigned FRAME_LEN_C = 80;
    localparam int unsigned SLOT_LEN_C  = 20;

    typedef enum logic {HUNT, LOCK} egress_state_t;

    typedef logic [DATA_W_C-1:0] xbar_word_t;

    // Index width that never collapses to zero bits for degenerate sizes.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/xbar_egress_demux_if.sv
// TDM bus ingress plus per-port egress valid/ready bundle of the crossbar receive end.
interface xbar_egress_demux_if
    import xbar_pkg::*;
#(
    parameter int unsigned PORTS  = PORTS_C,
    parameter int unsigned DATA_W = DATA_W_C
);

    logic                    frame_sync;
    logic                    slot_sync;
    logic                    sample_en;
    logic                    bus_valid;
    logic [DATA_W-1:0]       bus_data;
    logic [PORTS*DATA_W-1:0] out_data;
    logic [PORTS-1:0]        out_valid;
    logic [PORTS-1:0]        out_ready;

    modport master (
        output frame_sync, slot_sync, sample_en, bus_valid, bus_data, out_ready,
        input  out_data, out_valid
    );

    modport slave (
        input  frame_sync, slot_sync, sample_en, bus_valid, bus_data, out_ready,
        output out_data, out_valid
    );

endinterface

// File: rtl/egress_fifo.sv
// First-word-fall-through synchronous FIFO; head word is presented combinationally.
module egress_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             rd_en;
    logic             wr_en;

    // A push into a full FIFO is accepted only when the head leaves on the same edge.
    always_comb begin
        empty = (wr_ptr == rd_ptr);
        full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        rd_en = pop && !empty;
        wr_en = push && (!full || rd_en);
        dout  = empty ? '0 : mem[rd_ptr[AW-1:0]];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/xbar_egress_demux.sv
// Tracks crossbar frame/slot timing from strobes and steers sampled bus words
// into per-slot egress FIFOs; strobe disagreement drops lock back to HUNT.
module xbar_egress_demux
    import xbar_pkg::*;
#(
    parameter int unsigned PORTS      = PORTS_C,
    parameter int unsigned DATA_W     = DATA_W_C,
    parameter int unsigned FRAME_LEN  = FRAME_LEN_C,
    parameter int unsigned SLOT_LEN   = SLOT_LEN_C,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    xbar_egress_demux_if.slave           xb,
    output logic [clog2_min1(PORTS)-1:0] slot_idx,
    output logic                         locked,
    output logic                         sync_err,
    output logic [PORTS-1:0]             overflow
);

    localparam int unsigned CW  = clog2_min1(FRAME_LEN);
    localparam int unsigned SIW = clog2_min1(PORTS);

    if (FRAME_LEN != PORTS * SLOT_LEN) begin : g_bad_frame
        $error("xbar_egress_demux: FRAME_LEN must equal PORTS*SLOT_LEN");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("xbar_egress_demux: FIFO_DEPTH must be a power of 2 and >= 2");
    end

    egress_state_t state;
    egress_state_t state_nx;
    logic [CW-1:0] cnt;
    logic [SIW-1:0] cur_slot;
    logic          exp_frame;
    logic          exp_slot;
    logic          mismatch;
    logic          capture;

    always_comb begin
        cur_slot  = SIW'(32'(cnt) / SLOT_LEN);
        exp_frame = (cnt == '0);
        exp_slot  = ((32'(cnt) % SLOT_LEN) == 0);
        mismatch  = (state == LOCK) &&
                    ((xb.frame_sync != exp_frame) || (xb.slot_sync != exp_slot));
    end

    always_ff @(posedge clk) begin
        if (rst) state <= HUNT;
        else     state <= state_nx;
    end

    // A frame_sync on the cycle that drops lock is not a re-lock; HUNT must see one itself.
    always_comb begin
        state_nx = state;
        case (state)
            HUNT:    if (xb.frame_sync) state_nx = LOCK;
            LOCK:    if (mismatch)      state_nx = HUNT;
            default: state_nx = HUNT;
        endcase
    end

    always_comb begin
        locked   = (state == LOCK);
        slot_idx = locked ? cur_slot : '0;
        sync_err = mismatch;
        capture  = locked && !mismatch && xb.sample_en && xb.bus_valid;
    end

    // The frame_sync cycle seen in HUNT is count 0, so LOCK begins at count 1.
    always_ff @(posedge clk) begin
        if (rst || state_nx == HUNT) begin
            cnt <= '0;
        end else if (state == HUNT) begin
            cnt <= CW'(1);
        end else if (cnt == CW'(FRAME_LEN - 1)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    for (genvar p = 0; p < PORTS; p++) begin : g_port
        logic push;
        logic full;
        logic empty;
        logic ovf;

        assign push            = capture && (cur_slot == SIW'(p));
        assign xb.out_valid[p] = !empty;
        assign overflow[p]     = ovf;

        egress_fifo #(
            .WIDTH (DATA_W),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (push),
            .din   (xb.bus_data),
            .pop   (xb.out_ready[p]),
            .dout  (xb.out_data[p*DATA_W +: DATA_W]),
            .empty (empty),
            .full  (full)
        );

        always_ff @(posedge clk) begin
            if (rst)                                  ovf <= 1'b0;
            else if (push && full && !xb.out_ready[p]) ovf <= 1'b1;
        end
    end

endmodule

// File: tb/tb_xbar_egress_demux.sv
// Directed bench for xbar_egress_demux: ideal strobe generator with injected faults,
// pop logging per port and hand-computed expected words.
module tb_xbar_egress_demux;
    import xbar_pkg::*;

    localparam int unsigned P = 4;
    localparam int unsigned W = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic [1:0]     slot_idx;
    logic           locked;
    logic           sync_err;
    logic [P-1:0]   overflow;

    always #5 clk = ~clk;

    xbar_egress_demux_if #(.PORTS(P), .DATA_W(W)) xb ();

    xbar_egress_demux #(
        .PORTS      (P),
        .DATA_W     (W),
        .FRAME_LEN  (80),
        .SLOT_LEN   (20),
        .FIFO_DEPTH (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .xb       (xb),
        .slot_idx (slot_idx),
        .locked   (locked),
        .sync_err (sync_err),
        .overflow (overflow)
    );

    int         checks = 0;
    int         errors = 0;
    int         g = 0;
    bit         gen_on = 1'b0;
    int         spur_fs = -1;
    int         kill_ss = -1;
    logic [P-1:0] rdy = '1;
    int         err_cnt = 0;
    int         err_g = -1;
    int         log_q [P][$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic xbar_word_t port_data(input int p);
        return xb.out_data[p*W +: W];
    endfunction

    // One bus cycle: drive strobes for phase g, log pops/errors before the edge.
    task automatic tick();
        xb.frame_sync = gen_on && (g == 0 || g == spur_fs);
        xb.slot_sync  = gen_on && (g % 20 == 0) && (g != kill_ss);
        xb.sample_en  = gen_on && (g % 10 == 1);
        xb.bus_valid  = gen_on;
        xb.bus_data   = W'(g);
        xb.out_ready  = rdy;
        @(negedge clk);
        for (int p = 0; p < P; p++)
            if (xb.out_valid[p] === 1'b1 && xb.out_ready[p] === 1'b1)
                log_q[p].push_back(int'(port_data(p)));
        if (sync_err === 1'b1) begin
            err_cnt++;
            err_g = g;
        end
        @(posedge clk);
        #1;
        g = (g + 1) % 80;
    endtask

    task automatic run_to(input int t);
        do tick(); while (g != t);
    endtask

    task automatic clear_logs();
        for (int p = 0; p < P; p++) log_q[p].delete();
    endtask

    task automatic check_log(input string tag, input int p, input int n,
                             input int e0 = 0, input int e1 = 0, input int e2 = 0,
                             input int e3 = 0, input int e4 = 0, input int e5 = 0);
        int e [6];
        e = '{e0, e1, e2, e3, e4, e5};
        check({tag, " count"}, log_q[p].size(), n);
        for (int i = 0; i < n && i < log_q[p].size(); i++)
            check({tag, " word"}, log_q[p][i], e[i]);
    endtask

    initial begin
        rst = 1'b1;
        tick();
        tick();
        check("rst locked",    locked,       0);
        check("rst slot_idx",  slot_idx,     0);
        check("rst sync_err",  sync_err,     0);
        check("rst out_valid", xb.out_valid, 0);
        check("rst overflow",  overflow,     0);
        check("rst out_data",  xb.out_data,  0);

        // 1: lock and steer
        rst = 1'b0;
        gen_on = 1'b1;
        g = 0;
        clear_logs();
        tick();
        check("t1 locked after frame_sync", locked, 1);
        check("t1 slot_idx cnt1", slot_idx, 0);
        run_to(45);
        check("t1 slot_idx cnt45", slot_idx, 2);
        run_to(0);
        check_log("t1 port0", 0, 2, 1, 11);
        check_log("t1 port1", 1, 2, 21, 31);
        check_log("t1 port2", 2, 2, 41, 51);
        check_log("t1 port3", 3, 2, 61, 71);
        check("t1 no sync_err", err_cnt, 0);
        clear_logs();

        // 2: backpressure overflow on port2
        rdy = 4'b1011;
        run_to(0);
        run_to(0);
        check("t2 overflow before 5th", overflow, 4'b0000);
        check("t2 port2 valid", xb.out_valid[2], 1);
        check("t2 port2 head", port_data(2), 41);
        check("t2 port2 no pops", log_q[2].size(), 0);
        run_to(42);
        check("t2 overflow after 5th", overflow, 4'b0100);
        run_to(0);
        clear_logs();
        rdy = 4'hF;
        run_to(10);
        check_log("t2 port2 drain", 2, 4, 41, 51, 41, 51);
        run_to(0);
        check("t2 overflow sticky", overflow, 4'b0100);
        clear_logs();

        // 3: missing slot_sync at cnt 40
        kill_ss = 40;
        run_to(40);
        tick();
        kill_ss = -1;
        check("t3 sync_err count", err_cnt, 1);
        check("t3 sync_err cnt", err_g, 40);
        check("t3 unlocked", locked, 0);
        check("t3 slot_idx hunt", slot_idx, 0);
        run_to(0);
        check_log("t3 port0", 0, 2, 1, 11);
        check_log("t3 port1", 1, 2, 21, 31);
        check_log("t3 port2 dropped", 2, 0);
        check_log("t3 port3 dropped", 3, 0);
        clear_logs();
        tick();
        check("t3 relock", locked, 1);
        run_to(0);
        check_log("t3 port3 relocked", 3, 2, 61, 71);
        check("t3 no extra sync_err", err_cnt, 1);
        clear_logs();

        // 4: spurious frame_sync at cnt 33, port1 held
        rdy = 4'b1101;
        spur_fs = 33;
        run_to(34);
        spur_fs = -1;
        check("t4 sync_err count", err_cnt, 2);
        check("t4 sync_err cnt", err_g, 33);
        check("t4 unlocked", locked, 0);
        check("t4 port1 kept", xb.out_valid[1], 1);
        check("t4 port1 head", port_data(1), 21);
        run_to(50);
        rdy = 4'hF;
        run_to(0);
        check_log("t4 port1 drain", 1, 2, 21, 31);
        check_log("t4 port0", 0, 2, 1, 11);
        check_log("t4 port2 dropped", 2, 0);
        clear_logs();

        // 5: full port0 with simultaneous push and pop
        rdy = 4'b1110;
        tick();
        check("t5 relock", locked, 1);
        run_to(0);
        run_to(0);
        check("t5 port0 valid", xb.out_valid[0], 1);
        check("t5 port0 head", port_data(0), 1);
        check("t5 port0 no pops", log_q[0].size(), 0);
        do begin
            rdy = {3'b111, (g == 1 || g == 11 || g >= 20) ? 1'b1 : 1'b0};
            tick();
        end while (g != 0);
        check_log("t5 port0 order", 0, 6, 1, 11, 1, 11, 1, 11);
        check("t5 overflow", overflow, 4'b0100);
        clear_logs();

        // 6: reset mid-frame
        rdy = '0;
        run_to(0);
        run_to(0);
        run_to(55);
        check("t6 pre valid", xb.out_valid, 4'hF);
        check("t6 pre overflow", overflow, 4'b0111);
        check("t6 pre slot_idx", slot_idx, 2);
        rst = 1'b1;
        tick();
        check("t6 out_valid", xb.out_valid, 0);
        check("t6 overflow", overflow, 0);
        check("t6 locked", locked, 0);
        check("t6 slot_idx", slot_idx, 0);
        check("t6 out_data", xb.out_data, 0);
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/xbar_egress_demux.md
Name: xbar_egress_demux

Overview:
- Receive end of the crossbar's time-division output bus. The crossbar control logic walks mux_sel across ports and emits frame, slot and sample strobes.
- This block tracks the same frame and slot timing from those strobes and recovers the active slot index.
- Each sampled bus word is steered into a per-port egress FIFO, drained downstream with a valid/ready handshake.
- Strobes that disagree with the locally tracked timing are detected, and the block re-acquires frame lock.

Parameters:
- PORTS, 4, number of egress ports; equals slots per frame.
- DATA_W, 8, bus and port data width.
- FRAME_LEN, 80, cycles per frame. Elaboration error unless FRAME_LEN == PORTS*SLOT_LEN.
- SLOT_LEN, 20, cycles per slot.
- FIFO_DEPTH, 4, words per egress FIFO; must be a power of 2 and ≥2.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- frame_sync  in  1  one-cycle frame-start strobe (clk80 timing)
- slot_sync  in  1  one-cycle slot-start strobe (clk20 timing)
- sample_en  in  1  sample strobe (clk10 timing); bus word is valid for capture only when high
- bus_valid  in  1  bus word qualifier
- bus_data  in  DATA_W  crossbar TDM bus data
- out_data  out  PORTS*DATA_W  per-port head-of-FIFO data; port p occupies bits [p*DATA_W +: DATA_W]
- out_valid  out  PORTS  per-port FIFO non-empty
- out_ready  in  PORTS  per-port downstream accept
- slot_idx  out  clog2(PORTS)  current slot while locked, 0 in HUNT
- locked  out  1  high in LOCK state
- sync_err  out  1  one-cycle pulse on strobe mismatch
- overflow  out  PORTS  sticky per-port drop flag, cleared only by rst

Behaviour:
- Reset values (rst high at a clk edge): state=HUNT, frame counter=0, slot_idx=0, locked=0, sync_err=0, overflow=0, all FIFOs empty, out_valid=0, out_data=0.
- FSM states:
  - HUNT: all bus samples are ignored. When frame_sync=1: go to LOCK, and the frame counter loads 1 on the next cycle. That cycle is count 0 and is not captured.
  - LOCK: the frame counter increments every cycle and wraps FRAME_LEN-1→0.
- Derived timing in LOCK:
  - slot_idx = cnt / SLOT_LEN.
  - frame_sync is expected exactly when cnt==0.
  - slot_sync is expected exactly when cnt % SLOT_LEN == 0.
- Mismatch in LOCK (either strobe present when not expected, or absent when expected):
  - sync_err pulses for 1 cycle and the next state is HUNT.
  - That cycle's sample is discarded.
  - FIFO contents are kept.
- Mismatch check vs. re-lock: a frame_sync arriving on the same cycle HUNT is entered does not count. Re-lock requires a frame_sync seen while in HUNT, i.e. at least one cycle later.
- Capture condition: LOCK && no mismatch this cycle && sample_en && bus_valid. The word is pushed into FIFO[slot_idx].
- FIFO behaviour:
  - First-word-fall-through: a word pushed at edge t is visible on out_data/out_valid after edge t, so latency is 1 cycle.
  - Pop when out_valid[p] && out_ready[p].
  - Full with simultaneous push and pop: both happen, occupancy is unchanged.
  - Full with push and no pop: the word is dropped and overflow[p] is set.
  - Empty with a push: out_valid rises next cycle. A pop is ignored because out_valid=0.
  - Pointers are clog2(FIFO_DEPTH)+1 bits, wrapping naturally. full = MSBs differ and LSBs equal; empty = pointers equal.
- out_ready has no effect on capture; ports are independent.
- rst mid-frame: immediate return to HUNT and everything flushed, overflow included.

Decomposition:
- xbar_pkg additions:
  - constants PORTS_C=4, DATA_W_C=8, FRAME_LEN_C=80, SLOT_LEN_C=20
  - typedef enum logic {HUNT, LOCK} egress_state_t
  - typedef logic [DATA_W_C-1:0] xbar_word_t
- Sub-module egress_fifo: parameterised FWFT synchronous FIFO (clk, rst, push, din, pop, dout, empty, full). Instantiated PORTS times via generate.
- Frame counter and FSM stay in the top module.

Test Plan:
1. Lock and steer:
   - Stimulus: rst 2 cycles, then ideal strobes (frame_sync every 80, slot_sync every 20, sample_en at cnt%10==1), bus_valid=1, bus_data=cnt, out_ready=all 1s.
   - Required: locked=1 one cycle after the first frame_sync. Port0 receives 1, 11; port1 receives 21, 31; port3 receives 61, 71. sync_err never asserts.
2. Backpressure overflow:
   - Stimulus: out_ready[2]=0 for 3 frames, then 1.
   - Required: port2 holds the first 4 words (41, 51, 41, 51), overflow[2]=1 from the 5th sample onward. After release, exactly those 4 words drain in order.
3. Missing slot_sync:
   - Stimulus: suppress slot_sync at cnt=40.
   - Required: sync_err pulses at that cycle, locked=0 next cycle, the cnt=41 word is not captured. Re-lock occurs on the next frame_sync.
4. Spurious frame_sync:
   - Stimulus: extra frame_sync at cnt=33.
   - Required: sync_err=1, return to HUNT, existing FIFO data still drains intact.
5. Full with push and pop together:
   - Stimulus: fill port0 to 4 words, then on a capture cycle assert out_ready[0]=1.
   - Required: occupancy stays 4, overflow[0] stays 0, output order is preserved.
6. Reset mid-frame:
   - Stimulus: rst=1 at cnt=55 with non-empty FIFOs and overflow[1]=1.
   - Required: next cycle out_valid=0, overflow=0, locked=0, slot_idx=0.
